// File: rtl/axil_rr_arbiter_if.sv
// rtl/axil_rr_arbiter_if.sv - N-master / 1-slave AXI4-Lite bundle seen by axil_rr_arbiter
interface axil_rr_arbiter_if #(
    parameter int NUM_M  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [NUM_M-1:0]        m_awvalid_i, m_awready_o;
    logic [NUM_M*ADDR_W-1:0] m_awaddr_i;
    logic [NUM_M-1:0]        m_wvalid_i, m_wready_o;
    logic [NUM_M*DATA_W-1:0] m_wdata_i;
    logic [NUM_M*STRB_W-1:0] m_wstrb_i;
    logic [NUM_M-1:0]        m_bvalid_o, m_bready_i;
    logic [2*NUM_M-1:0]      m_bresp_o;
    logic [NUM_M-1:0]        m_arvalid_i, m_arready_o;
    logic [NUM_M*ADDR_W-1:0] m_araddr_i;
    logic [NUM_M-1:0]        m_rvalid_o, m_rready_i;
    logic [NUM_M*DATA_W-1:0] m_rdata_o;
    logic [2*NUM_M-1:0]      m_rresp_o;

    logic              s_awvalid_o, s_awready_i;
    logic [ADDR_W-1:0] s_awaddr_o;
    logic              s_wvalid_o, s_wready_i;
    logic [DATA_W-1:0] s_wdata_o;
    logic [STRB_W-1:0] s_wstrb_o;
    logic              s_bvalid_i, s_bready_o;
    logic [1:0]        s_bresp_i;
    logic              s_arvalid_o, s_arready_i;
    logic [ADDR_W-1:0] s_araddr_o;
    logic              s_rvalid_i, s_rready_o;
    logic [DATA_W-1:0] s_rdata_i;
    logic [1:0]        s_rresp_i;

    // Arbiter side
    modport slave (
        input  m_awvalid_i, m_awaddr_i, m_wvalid_i, m_wdata_i, m_wstrb_i, m_bready_i,
        input  m_arvalid_i, m_araddr_i, m_rready_i,
        output m_awready_o, m_wready_o, m_bvalid_o, m_bresp_o,
        output m_arready_o, m_rvalid_o, m_rdata_o, m_rresp_o,
        output s_awvalid_o, s_awaddr_o, s_wvalid_o, s_wdata_o, s_wstrb_o, s_bready_o,
        output s_arvalid_o, s_araddr_o, s_rready_o,
        input  s_awready_i, s_wready_i, s_bvalid_i, s_bresp_i,
        input  s_arready_i, s_rvalid_i, s_rdata_i, s_rresp_i
    );

    // Environment side: drives the masters and models the downstream slave
    modport master (
        output m_awvalid_i, m_awaddr_i, m_wvalid_i, m_wdata_i, m_wstrb_i, m_bready_i,
        output m_arvalid_i, m_araddr_i, m_rready_i,
        input  m_awready_o, m_wready_o, m_bvalid_o, m_bresp_o,
        input  m_arready_o, m_rvalid_o, m_rdata_o, m_rresp_o,
        input  s_awvalid_o, s_awaddr_o, s_wvalid_o, s_wdata_o, s_wstrb_o, s_bready_o,
        input  s_arvalid_o, s_araddr_o, s_rready_o,
        output s_awready_i, s_wready_i, s_bvalid_i, s_bresp_i,
        output s_arready_i, s_rvalid_i, s_rdata_i, s_rresp_i
    );
endinterface

// File: rtl/axil_rr_arbiter.sv
// rtl/axil_rr_arbiter.sv - N:1 AXI4-Lite round-robin arbiter, independent read/write paths
// Optional per-master completion counters under AXIL_ARB_STATS_EN.
module axil_rr_arbiter #(
    parameter int NUM_M  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef AXIL_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                    core_clk,
    input  logic                    core_rst_n,
    axil_rr_arbiter_if.slave        bus,
    output logic [NUM_M-1:0]        wr_gnt_o,
    output logic [NUM_M-1:0]        rd_gnt_o
`ifdef AXIL_ARB_STATS_EN
    ,
    input  logic                    stat_clr_i,
    output logic [NUM_M*CNT_W-1:0]  stat_wr_o,
    output logic [NUM_M*CNT_W-1:0]  stat_rd_o
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(NUM_M);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;

    // First requester at or after ptr, wrapping NUM_M-1 -> 0
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (!found && req[PTR_W'(idx)]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_M - 1)) ? '0 : idx + 1'b1;
    endfunction

    // ---------------- write path ----------------
    state_t           wr_state_q, wr_state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_idx_q, wr_pick;
    logic [NUM_M-1:0] wr_gnt_q;
    logic             aw_done_q, w_done_q;
    logic             aw_hs, w_hs, b_hs, aw_fin, w_fin;

    assign wr_pick  = rr_pick(bus.m_awvalid_i, wr_ptr_q);
    assign aw_hs    = bus.s_awvalid_o & bus.s_awready_i;
    assign w_hs     = bus.s_wvalid_o & bus.s_wready_i;
    assign b_hs     = bus.s_bvalid_i & bus.s_bready_o;
    assign aw_fin   = aw_done_q | aw_hs;
    assign w_fin    = w_done_q | w_hs;
    assign wr_gnt_o = wr_gnt_q;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) wr_state_q <= ST_IDLE;
        else             wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            ST_IDLE: if (|bus.m_awvalid_i) wr_state_d = ST_ADDR;
            ST_ADDR: if (aw_fin && w_fin)  wr_state_d = ST_RESP;
            ST_RESP: if (b_hs)             wr_state_d = ST_IDLE;
            default:                       wr_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            wr_ptr_q  <= '0;
            wr_idx_q  <= '0;
            wr_gnt_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (wr_state_q)
                ST_IDLE: if (|bus.m_awvalid_i) begin
                    wr_idx_q <= wr_pick;
                    wr_gnt_q <= NUM_M'(1) << wr_pick;
                end
                ST_ADDR: begin
                    aw_done_q <= aw_fin;
                    w_done_q  <= w_fin;
                end
                ST_RESP: if (b_hs) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    wr_gnt_q  <= '0;
                    wr_ptr_q  <= next_ptr(wr_idx_q);
                end
                default: ;
            endcase
        end
    end

    // Done flags stop each channel from being forwarded a second time
    always_comb begin
        bus.m_awready_o = '0;
        bus.m_wready_o  = '0;
        bus.m_bvalid_o  = '0;
        bus.m_bresp_o   = '0;
        bus.s_awvalid_o = 1'b0;
        bus.s_wvalid_o  = 1'b0;
        bus.s_bready_o  = 1'b0;
        bus.s_awaddr_o  = bus.m_awaddr_i[int'(wr_idx_q)*ADDR_W +: ADDR_W];
        bus.s_wdata_o   = bus.m_wdata_i[int'(wr_idx_q)*DATA_W +: DATA_W];
        bus.s_wstrb_o   = bus.m_wstrb_i[int'(wr_idx_q)*STRB_W +: STRB_W];
        case (wr_state_q)
            ST_ADDR: begin
                bus.s_awvalid_o           = bus.m_awvalid_i[wr_idx_q] & ~aw_done_q;
                bus.s_wvalid_o            = bus.m_wvalid_i[wr_idx_q] & ~w_done_q;
                bus.m_awready_o[wr_idx_q] = bus.s_awready_i & ~aw_done_q;
                bus.m_wready_o[wr_idx_q]  = bus.s_wready_i & ~w_done_q;
            end
            ST_RESP: begin
                bus.s_bready_o                        = bus.m_bready_i[wr_idx_q];
                bus.m_bvalid_o[wr_idx_q]              = bus.s_bvalid_i;
                bus.m_bresp_o[int'(wr_idx_q)*2 +: 2]  = bus.s_bresp_i;
            end
            default: ;
        endcase
    end

    // ---------------- read path ----------------
    state_t           rd_state_q, rd_state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_idx_q, rd_pick;
    logic [NUM_M-1:0] rd_gnt_q;
    logic             ar_hs, r_hs;

    assign rd_pick  = rr_pick(bus.m_arvalid_i, rd_ptr_q);
    assign ar_hs    = bus.s_arvalid_o & bus.s_arready_i;
    assign r_hs     = bus.s_rvalid_i & bus.s_rready_o;
    assign rd_gnt_o = rd_gnt_q;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) rd_state_q <= ST_IDLE;
        else             rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            ST_IDLE: if (|bus.m_arvalid_i) rd_state_d = ST_ADDR;
            ST_ADDR: if (ar_hs)            rd_state_d = ST_RESP;
            ST_RESP: if (r_hs)             rd_state_d = ST_IDLE;
            default:                       rd_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rd_ptr_q <= '0;
            rd_idx_q <= '0;
            rd_gnt_q <= '0;
        end else begin
            case (rd_state_q)
                ST_IDLE: if (|bus.m_arvalid_i) begin
                    rd_idx_q <= rd_pick;
                    rd_gnt_q <= NUM_M'(1) << rd_pick;
                end
                ST_RESP: if (r_hs) begin
                    rd_gnt_q <= '0;
                    rd_ptr_q <= next_ptr(rd_idx_q);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.m_arready_o = '0;
        bus.m_rvalid_o  = '0;
        bus.m_rdata_o   = '0;
        bus.m_rresp_o   = '0;
        bus.s_arvalid_o = 1'b0;
        bus.s_rready_o  = 1'b0;
        bus.s_araddr_o  = bus.m_araddr_i[int'(rd_idx_q)*ADDR_W +: ADDR_W];
        case (rd_state_q)
            ST_ADDR: begin
                bus.s_arvalid_o           = bus.m_arvalid_i[rd_idx_q];
                bus.m_arready_o[rd_idx_q] = bus.s_arready_i;
            end
            ST_RESP: begin
                bus.s_rready_o                              = bus.m_rready_i[rd_idx_q];
                bus.m_rvalid_o[rd_idx_q]                    = bus.s_rvalid_i;
                bus.m_rdata_o[int'(rd_idx_q)*DATA_W +: DATA_W] = bus.s_rdata_i;
                bus.m_rresp_o[int'(rd_idx_q)*2 +: 2]        = bus.s_rresp_i;
            end
            default: ;
        endcase
    end

`ifdef AXIL_ARB_STATS_EN
    // Saturating per-master completion counters; clear has priority
    for (genvar g = 0; g < NUM_M; g++) begin : g_stat
        logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;

        always_ff @(posedge core_clk or negedge core_rst_n) begin
            if (!core_rst_n) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else if (stat_clr_i) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (b_hs && wr_idx_q == PTR_W'(g) && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 1'b1;
                if (r_hs && rd_idx_q == PTR_W'(g) && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 1'b1;
            end
        end

        assign stat_wr_o[g*CNT_W +: CNT_W] = wr_cnt_q;
        assign stat_rd_o[g*CNT_W +: CNT_W] = rd_cnt_q;
    end
`endif
endmodule

// File: doc/axil_rr_arbiter.md
Name: axil_rr_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4-Lite arbiter for multi-core SoC builds, e.g. several picorv32 cores or a core plus DMA sharing one AXI-Lite interconnect port.
- Write and read paths arbitrate independently, each with its own round-robin pointer.
- One outstanding transaction per path.
- Sits between the core bus adapters and the memory/peripheral crossbar in the SoC top.

Parameters:
- NUM_M, 4, number of masters (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (32 or 64); strobe width is DATA_W/8.
- CNT_W, 16, statistics counter width (optional feature only).

Ports:
- core_clk input 1 clock.
- core_rst_n input 1 async active-low reset.
- m_awvalid_i input NUM_M, m_awready_o output NUM_M, m_awaddr_i input NUM_M*ADDR_W: master AW channels, packed with master i at slice i.
- m_wvalid_i input NUM_M, m_wready_o output NUM_M, m_wdata_i input NUM_M*DATA_W, m_wstrb_i input NUM_M*DATA_W/8: master W channels.
- m_bvalid_o output NUM_M, m_bready_i input NUM_M, m_bresp_o output 2*NUM_M: master B channels.
- m_arvalid_i input NUM_M, m_arready_o output NUM_M, m_araddr_i input NUM_M*ADDR_W: master AR channels.
- m_rvalid_o output NUM_M, m_rready_i input NUM_M, m_rdata_o output NUM_M*DATA_W, m_rresp_o output 2*NUM_M: master R channels.
- s_awvalid_o, s_awready_i, s_awaddr_o, s_wvalid_o, s_wready_i, s_wdata_o, s_wstrb_o, s_bvalid_i, s_bready_o, s_bresp_i: slave write port (widths as one master).
- s_arvalid_o, s_arready_i, s_araddr_o, s_rvalid_i, s_rready_o, s_rdata_i, s_rresp_i: slave read port.
- wr_gnt_o output NUM_M: one-hot current write owner, 0 when idle.
- rd_gnt_o output NUM_M: one-hot current read owner, 0 when idle.

Behaviour:
- Reset (core_rst_n low, asynchronous): both FSMs in IDLE; both grants 0; all valid/ready outputs 0; round-robin pointers select master 0 as first candidate; aw_done/w_done cleared.
- Write FSM states: IDLE, ADDR, RESP.
  - IDLE: if any m_awvalid_i[i], pick the first requester at or after the pointer (wrapping NUM_M-1 -> 0). Register wr_gnt_o and go to ADDR. Request-to-s_awvalid_o latency is 1 cycle.
  - ADDR: combinationally forward the granted master's AW and W to the slave; all other masters see ready=0.
    - aw_done sets on the AW handshake, w_done on the W handshake; each channel passes exactly once.
    - AW and W may complete in either order or in the same cycle.
    - When both are done, go to RESP; s_awvalid_o and s_wvalid_o are 0 after their handshakes.
  - RESP: s_bready_o = m_bready_i[gnt]; m_bvalid_o[gnt] = s_bvalid_i; bresp passes through.
    - On the B handshake, return to IDLE, clear the done flags, set the pointer to gnt+1 mod NUM_M, clear the grant.
    - The next grant is decided no earlier than the cycle after the B handshake.
- Read FSM states: IDLE, ADDR, RESP.
  - Same arbitration on m_arvalid_i.
  - ADDR forwards AR until the handshake, then RESP.
  - RESP forwards R (data, resp) to the owner until the R handshake, then IDLE with the pointer advanced.
- Read and write to the same or different masters proceed concurrently; no ordering between paths.
- A master that deasserts valid before grant is simply skipped. A master granted in IDLE must hold valid (AXI rule); no re-arbitration until completion.
- Non-owner m_bvalid_o/m_rvalid_o are 0; non-owner m_rdata_o/m_bresp_o are 0.
- Reset mid-transaction aborts to IDLE immediately; the slave is expected to be reset by the same signal.

Optional Feature:
- Macro: AXIL_ARB_STATS_EN.
- When defined, adds ports stat_clr_i (input 1), stat_wr_o (output NUM_M*CNT_W) and stat_rd_o (output NUM_M*CNT_W).
- Per-master counters increment by 1 on each completed B (or R) handshake for that master and saturate at all-ones.
- stat_clr_i high zeroes all counters on the next edge; clear wins over a simultaneous increment.
- Counters reset to 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single write: master 2 sends AW 0x1000 and W 0xDEADBEEF/strb 0xF together, slave ready -> s_awvalid_o rises 1 cycle later, wr_gnt_o=0b0100, bresp OKAY routed only to master 2, grant clears after the B handshake.
- Round-robin: all 4 masters hold arvalid continuously, slave responds in 1 cycle -> grant order 0,1,2,3,0; no master granted twice before the others.
- W before AW: master 1 presents W 3 cycles before AW, slave s_wready_i=1 always -> W passes once, AW passes once, single B returned, no duplicate W beat.
- Concurrent paths: master 0 writes while master 3 reads, slave delays B by 5 cycles -> read completes independently; rd_gnt_o=0b1000 and wr_gnt_o=0b0001 simultaneously.
- Backpressure: master 1 holds m_rready_i=0 for 4 cycles after s_rvalid_i -> s_rready_o=0, data 0x12345678 held, no other read granted until the handshake.
- Reset mid-transaction: assert core_rst_n=0 in write ADDR state -> all outputs 0 asynchronously; after release, master 0 is first served. With AXIL_ARB_STATS_EN, 3 reads by master 1 give stat_rd_o slice 1 = 3, and stat_clr_i zeroes it.
